// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
//   One quotient bit is produced per clock. The final result is returned as
//   {remainder, quotient}. The execute stage writes the remainder to HI and
//   the quotient to LO.
//
//   Handshake: start_i acts as the request valid. The execute stage raises it
//   together with the operands and holds it until it sees ready_o. ready_o
//   acts as the response valid, and result_o is valid only while ready_o is
//   high. When the execute stage lowers start_i, the result is consumed and
//   the unit goes back to FREE on the next edge. annul_i cancels a divide in
//   flight. It has no effect once the result is ready.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled with start
//   opdata1_i     dividend, sampled with start
//   opdata2_i     divisor, sampled with start
//   start_i       divide request, held until ready_o
//   annul_i       flush: abort an in-flight divide
//   result_o      {remainder, quotient}, zero while ready_o is low
//   ready_o       result_o valid
//   state_dbg     current FSM state (FREE=0, BYZERO=1, ON=2, END=3)
// ----------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic [1:0]           state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);
   // The counter runs 0..WIDTH-1 for the shift/subtract steps. The value
   // WIDTH marks the extra edge that sign-corrects and publishes the result.
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t               state_q, state_n;
   logic [CW-1:0]        cnt_q, cnt_n;
   logic [WIDTH-1:0]     quo_q, quo_n;   // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0]     rem_q, rem_n;   // partial remainder
   logic [WIDTH-1:0]     dvs_q, dvs_n;   // divisor magnitude
   logic                 neg_quo_q, neg_quo_n;
   logic                 neg_rem_q, neg_rem_n;
   logic [2*WIDTH-1:0]   result_n;
   logic                 ready_n;

   logic [WIDTH-1:0]     op1_abs, op2_abs;
   logic [WIDTH:0]       rem_shift, diff;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Take magnitudes only for signed divides with a negative operand.
   // For the most negative value, the wrapped magnitude is still correct
   // as an unsigned value.
   assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // One restoring step: bring in the next dividend bit and try to subtract.
   // If diff[WIDTH] is set, the trial went negative and is discarded.
   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign diff      = rem_shift - {1'b0, dvs_q};

   assign quo_fix = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix = neg_rem_q ? -rem_q : rem_q;

   assign state_dbg = state_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FREE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         quo_q     <= quo_n;
         rem_q     <= rem_n;
         dvs_q     <= dvs_n;
         neg_quo_q <= neg_quo_n;
         neg_rem_q <= neg_rem_n;
         result_o  <= result_n;
         ready_o   <= ready_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      quo_n     = quo_q;
      rem_n     = rem_q;
      dvs_n     = dvs_q;
      neg_quo_n = neg_quo_q;
      neg_rem_n = neg_rem_q;
      result_n  = result_o;
      ready_n   = ready_o;

      case (state_q)
         S_FREE: begin
            ready_n  = 1'b0;
            result_n = '0;
            if (start_i && !annul_i) begin
               cnt_n = '0;
               if (opdata2_i == '0) begin
                  state_n = S_BYZERO;
               end else begin
                  quo_n     = op1_abs;
                  dvs_n     = op2_abs;
                  rem_n     = '0;
                  neg_quo_n = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  neg_rem_n = signed_div_i && opdata1_i[WIDTH-1];
                  state_n   = S_ON;
               end
            end
         end

         S_BYZERO: begin
            // A divide by zero spends two edges here, then returns zero
            // without raising any exception.
            if (annul_i) begin
               state_n = S_FREE;
            end else if (cnt_q != '0) begin
               result_n = '0;
               ready_n  = 1'b1;
               state_n  = S_END;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end

         S_ON: begin
            if (annul_i) begin
               state_n = S_FREE;
            end else if (cnt_q == CNT_LAST) begin
               result_n = {rem_fix, quo_fix};
               ready_n  = 1'b1;
               state_n  = S_END;
            end else begin
               if (!diff[WIDTH]) begin
                  rem_n = diff[WIDTH-1:0];
                  quo_n = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_n = rem_shift[WIDTH-1:0];
                  quo_n = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_n = cnt_q + CW'(1);
            end
         end

         S_END: begin
            if (!start_i) begin
               state_n  = S_FREE;
               ready_n  = 1'b0;
               result_n = '0;
            end
         end

         default: begin
            state_n = S_FREE;
         end
      endcase
   end

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//   Directed bench for div_unit. It covers unsigned and signed divides,
//   divide by zero, signed overflow, annul, and reset mid-divide and in END.
//   A short run of random operands is checked against a behavioural model.
// ----------------------------------------------------------------------------
module tb_div_unit;

   localparam int W = 32;
   localparam logic [1:0] ST_FREE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd2;

   logic           clk;
   logic           rst;
   logic           signed_div;
   logic [W-1:0]   opdata1;
   logic [W-1:0]   opdata2;
   logic           start;
   logic           annul;
   logic [2*W-1:0] result;
   logic           ready;
   logic [1:0]     state_dbg;

   int n_assert = 0;
   int n_fail   = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model, written with the language's own divide operators.
   function automatic logic [63:0] golden(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] q;
      logic signed [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (!sgn) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   // Full transaction: issue, scramble operands after the sampling edge,
   // wait for ready, hold one cycle with annul asserted (ignored in END),
   // then release.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_edges);
      int edges;
      @(negedge clk);
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      edges      = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) begin
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = ~sgn;
         end
      end while (!ready && edges < 50);
      check({tag, " latency"}, 64'(edges), 64'(exp_edges));
      check({tag, " ready"}, 64'(ready), 64'd1);
      check({tag, " result"}, result, exp);
      @(negedge clk);
      annul = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " hold ready"}, 64'(ready), 64'd1);
      check({tag, " hold result"}, result, exp);
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " drop ready"}, 64'(ready), 64'd0);
      check({tag, " drop result"}, result, 64'd0);
      check({tag, " drop state"}, 64'(state_dbg), 64'(ST_FREE));
   endtask

   initial begin
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;

      rst        = 1'b0;
      signed_div = 1'b0;
      opdata1    = '0;
      opdata2    = '0;
      start      = 1'b0;
      annul      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      check("reset state", 64'(state_dbg), 64'(ST_FREE));
      @(negedge clk);
      rst = 1'b1;

      // basic unsigned, signed sign handling, divide by zero, overflow
      run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 34);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34);
      run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 64'd0, 3);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34);
      run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);
      run_div("divu_big", 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h00000001_7FFFFFFC, 34);

      // annul at iteration 10
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd100;
      opdata2    = 32'd7;
      start      = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check("annul pre state", 64'(state_dbg), 64'(ST_ON));
      @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("annul state", 64'(state_dbg), 64'(ST_FREE));
      check("annul ready", 64'(ready), 64'd0);
      @(negedge clk);
      annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("annul no ready", 64'(ready), 64'd0);
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

      // annul while in the divide-by-zero path
      @(negedge clk);
      opdata2 = 32'd0;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("annul byzero state", 64'(state_dbg), 64'(ST_FREE));
      @(negedge clk);
      annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("annul byzero ready", 64'(ready), 64'd0);

      // reset at iteration 20
      @(negedge clk);
      signed_div = 1'b1;
      opdata1    = 32'h0000_1000;
      opdata2    = 32'd3;
      start      = 1'b1;
      repeat (21) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("rst mid state", 64'(state_dbg), 64'(ST_FREE));
      check("rst mid ready", 64'(ready), 64'd0);
      check("rst mid result", result, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // reset while in END with start held
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd50;
      opdata2    = 32'd5;
      start      = 1'b1;
      repeat (34) @(posedge clk);
      #1;
      check("end before rst ready", 64'(ready), 64'd1);
      check("end before rst result", result, 64'h00000000_0000000A);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst end ready", 64'(ready), 64'd0);
      check("rst end result", result, 64'd0);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;

      // random operands against the model
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 20);
            3:       b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         run_div($sformatf("rand%0d", i), sgn, a, b, golden(sgn, a, b), (b == 32'd0) ? 3 : 34);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
